// File: rtl/bcd_display_scan_pkg.sv
// ============================================================================
// Module      : bcd_disp_pkg
// Description : Shared constants for the two-digit seven-segment scanner.
//               Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
//               Anode patterns are active-low, An[0]=ones digit, An[1]=tens digit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bcd_disp_pkg;

    // Digit patterns, active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;   // invalid BCD (10..15)
    localparam logic [6:0] SEG_BLANK = 7'b1111111;   // all segments off

    // Anode patterns, active-low
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;
    localparam logic [1:0] AN_OFF  = 2'b11;

endpackage : bcd_disp_pkg

`default_nettype wire

// File: rtl/bcd_display_scan_if.sv
// ============================================================================
// Module      : bcd_display_scan_if
// Description : Digit-capture and display bus for bcd_display_scan.
//               Load/Tens/Ones : capture strobe and BCD digits (master -> slave)
//               An/Seg         : active-low anode enables and segments
//               DigitSel       : scan slot that produced An/Seg (0=ones, 1=tens)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bcd_display_scan_if;

    logic       Load;
    logic [3:0] Tens;
    logic [3:0] Ones;
    logic [1:0] An;
    logic [6:0] Seg;
    logic       DigitSel;

    // Digit source / display observer
    modport master (
        output Load,
        output Tens,
        output Ones,
        input  An,
        input  Seg,
        input  DigitSel
    );

    // Display scanner
    modport slave (
        input  Load,
        input  Tens,
        input  Ones,
        output An,
        output Seg,
        output DigitSel
    );

endinterface : bcd_display_scan_if

`default_nettype wire

// File: rtl/bcd_to_seg.sv
// ============================================================================
// Module      : bcd_to_seg
// Description : Combinational BCD to active-low seven-segment encoder.
//               Codes 10..15 are not valid BCD and show a dash.
// Ports       : d_i   [3:0] BCD digit
//               seg_o [6:0] active-low segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_to_seg
    import bcd_disp_pkg::*;
(
    input  wire logic [3:0] d_i,
    output logic      [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (d_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule : bcd_to_seg

`default_nettype wire

// File: rtl/bcd_display_scan.sv
// ============================================================================
// Module      : bcd_display_scan
// Description : Two-digit, common-anode, time-multiplexed seven-segment
//               driver. Captures Tens/Ones on Load, scans the two digits with
//               a REFRESH_DIV-cycle slot, and registers all display outputs.
// Ports       : Clk  - system clock, rising edge
//               Rst  - asynchronous active-high reset
//               bus  - bcd_display_scan_if.slave (Load/Tens/Ones in,
//                      An/Seg/DigitSel out)
// Parameters  : REFRESH_DIV - clock cycles per digit slot (2 .. 2^20)
//               CNT_W       - prescaler width, 2^CNT_W >= REFRESH_DIV
// Options     : LEADING_ZERO_BLANK_EN - when defined, a tens digit of 0 is
//               blanked (slot timing unchanged).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_display_scan
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 20
) (
    input  wire logic          Clk,
    input  wire logic          Rst,
    bcd_display_scan_if.slave  bus
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             sel_q,   sel_d;
    logic [3:0]       htens_q, htens_d;
    logic [3:0]       hones_q, hones_d;
    logic [1:0]       an_q,    an_d;
    logic [6:0]       seg_q,   seg_d;
    logic             dsel_q,  dsel_d;

    logic             w_tick;
    logic [3:0]       w_digit;
    logic [6:0]       w_seg_enc;

    // ------------------------------------------------------------------
    // Prescaler and scan select
    // ------------------------------------------------------------------
    assign w_tick = (cnt_q == C_CNT_LAST);

    always_comb begin
        cnt_d = w_tick ? '0 : cnt_q + 1'b1;
        sel_d = w_tick ? ~sel_q : sel_q;
    end

    // ------------------------------------------------------------------
    // Digit capture. The output stage below reads the pre-edge held
    // digits together with the pre-edge slot, so a Load that lands on a
    // tick edge never pairs an old slot with a new digit.
    // ------------------------------------------------------------------
    always_comb begin
        htens_d = bus.Load ? bus.Tens : htens_q;
        hones_d = bus.Load ? bus.Ones : hones_q;
    end

    // ------------------------------------------------------------------
    // Output stage: one shared encoder fed by the digit for the current slot
    // ------------------------------------------------------------------
    assign w_digit = sel_q ? htens_q : hones_q;

    bcd_to_seg u_bcd_to_seg (
        .d_i   (w_digit),
        .seg_o (w_seg_enc)
    );

    always_comb begin
        an_d   = sel_q ? AN_TENS : AN_ONES;
        seg_d  = w_seg_enc;
        dsel_d = sel_q;
`ifdef LEADING_ZERO_BLANK_EN
        if (sel_q && (htens_q == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
`endif
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            htens_q <= 4'd0;
            hones_q <= 4'd0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
            dsel_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            htens_q <= htens_d;
            hones_q <= hones_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dsel_q  <= dsel_d;
        end
    end

    assign bus.An       = an_q;
    assign bus.Seg      = seg_q;
    assign bus.DigitSel = dsel_q;

endmodule : bcd_display_scan

`default_nettype wire

// File: tb/tb_bcd_display_scan.sv
// ============================================================================
// Module      : tb_bcd_display_scan
// Description : Self-checking bench for bcd_display_scan with REFRESH_DIV=4.
//               A reference model tracks edges since reset and the held
//               digits, and predicts An/Seg/DigitSel after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_display_scan;

    localparam int C_DIV = 4;

    logic Clk;
    logic Rst;

    bcd_display_scan_if bus ();

    bcd_display_scan #(
        .REFRESH_DIV (C_DIV),
        .CNT_W       (3)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_err;
    int n_chk;

    // Reference model state
    int         m_edges;   // rising edges since reset release
    logic [3:0] m_tens;
    logic [3:0] m_ones;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] tbl [0:9];
        tbl[0] = 7'b1000000; tbl[1] = 7'b1111001; tbl[2] = 7'b0100100;
        tbl[3] = 7'b0110000; tbl[4] = 7'b0011001; tbl[5] = 7'b0010010;
        tbl[6] = 7'b0000010; tbl[7] = 7'b1111000; tbl[8] = 7'b0000000;
        tbl[9] = 7'b0010000;
        return (d <= 4'd9) ? tbl[d] : 7'b0111111;
    endfunction

    // One clock with the given inputs; called at a falling edge.
    task automatic cycle(input logic ld, input logic [3:0] t, input logic [3:0] o);
        int         slot;
        logic [1:0] exp_an;
        logic [6:0] exp_seg;
        bus.Load = ld;
        bus.Tens = t;
        bus.Ones = o;
        // Slot in force before this edge: digits alternate every C_DIV edges
        slot    = (m_edges / C_DIV) % 2;
        exp_an  = (slot == 1) ? 2'b01 : 2'b10;
        exp_seg = (slot == 1) ? enc(m_tens) : enc(m_ones);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 1 && m_tens == 4'd0) exp_seg = 7'b1111111;
`endif
        if (ld) begin
            m_tens = t;
            m_ones = o;
        end
        m_edges++;
        @(posedge Clk);
        @(negedge Clk);
        chk("an",       int'(bus.An),       int'(exp_an));
        chk("seg",      int'(bus.Seg),      int'(exp_seg));
        chk("digitsel", int'(bus.DigitSel), slot);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, bus.Tens, bus.Ones);
    endtask

    initial begin
        n_err    = 0;
        n_chk    = 0;
        Rst      = 1'b1;
        bus.Load = 1'b1;           // must be ignored while in reset
        bus.Tens = 4'd9;
        bus.Ones = 4'd8;

        // Reset state, with clocks running and Load high
        repeat (3) @(negedge Clk);
        chk("rst_an",  int'(bus.An),       2'b11);
        chk("rst_seg", int'(bus.Seg),      7'h7F);
        chk("rst_ds",  int'(bus.DigitSel), 0);

        Rst      = 1'b0;
        bus.Load = 1'b0;
        m_edges  = 0;
        m_tens   = 4'd0;
        m_ones   = 4'd0;

        // Idle after reset: both slots show held zeros
        idle(10);

        // Capture 1/5, then change inputs without Load
        cycle(1'b1, 4'd1, 4'd5);
        idle(3);
        cycle(1'b0, 4'd7, 4'd2);
        idle(9);

        // Invalid BCD in the ones digit
        cycle(1'b1, 4'd1, 4'hC);
        idle(9);

        // Load exactly on the tick edge (last cycle of a slot)
        while ((m_edges % C_DIV) != C_DIV - 1) cycle(1'b0, 4'd0, 4'd0);
        cycle(1'b1, 4'd9, 4'd7);
        idle(8);

        // Leading-zero tens digit
        cycle(1'b1, 4'd0, 4'd3);
        idle(9);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 3) == 0),
                  4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset mid-scan while in the tens slot
        cycle(1'b1, 4'd6, 4'd4);
        while (((m_edges / C_DIV) % 2) != 1 || (m_edges % C_DIV) == 0)
            cycle(1'b0, bus.Tens, bus.Ones);
        chk("pre_rst_an", int'(bus.An), 2'b01);
        #2;
        Rst      = 1'b1;
        bus.Load = 1'b1;
        #1;
        chk("arst_an",  int'(bus.An),       2'b11);
        chk("arst_seg", int'(bus.Seg),      7'h7F);
        chk("arst_ds",  int'(bus.DigitSel), 0);
        @(negedge Clk);
        Rst     = 1'b0;
        m_edges = 0;
        m_tens  = 4'd0;
        m_ones  = 4'd0;
        idle(12);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_bcd_display_scan

`default_nettype wire
